// File: rtl/serial_adder_controller_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, default
// width and a gate-level incrementer used by the bit counter.
package serial_adder_controller_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ripple increment built from XOR/AND so the block contains no '+' operator.
  function automatic logic [31:0] incr32(input logic [31:0] v);
    logic [31:0] r;
    logic        c;
    r = '0;
    c = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      r[i] = v[i] ^ c;
      c    = v[i] & c;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_controller_full_adder.sv
// One-bit full-adder cell built from gate primitives; the only arithmetic
// element of the serial adder.
module structuralFullAdder (
  output logic sum,
  output logic carryout,
  input  logic a,
  input  logic b,
  input  logic carryin
);

  logic ab_x;
  logic ab_a;
  logic xc_a;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (sum, ab_x, carryin);
  and g_a0 (ab_a, a, b);
  and g_a1 (xc_a, ab_x, carryin);
  or  g_o0 (carryout, ab_a, xc_a);

endmodule

// File: rtl/serial_adder_controller.sv
// Bit-serial adder: one full-adder cell sequenced LSB first over WIDTH
// cycles, with operand shift registers, a carry register and a bit counter.
module serial_adder_controller
  import serial_adder_controller_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_cout;

  structuralFullAdder u_fa (
    .sum      (fa_sum),
    .carryout (fa_cout),
    .a        (a_sh[0]),
    .b        (b_sh[0]),
    .carryin  (carry)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: accept start in IDLE, leave RUN on the last bit, DONE lasts one cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand load, per-bit shift/carry update and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= carryin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
          carry  <= fa_cout;
          cnt    <= CNT_W'(incr32(32'(cnt)));
          if (cnt == LAST) begin
            // The MSB sum bit is still on the cell output, so the final
            // result is assembled from the cell and the partial register.
            sum      <= {fa_sum, res_sh[WIDTH-1:1]};
            carryout <= fa_cout;
            overflow <= carry ^ fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_controller.sv
// Self-checking bench for serial_adder_controller (WIDTH = 8): directed
// corner cases plus randomized adds against an arithmetic reference model.
module tb_serial_adder_controller;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carryin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carryout;
  logic         overflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Results the DUT should currently be holding.
  logic [W-1:0] held_sum  = '0;
  logic         held_cout = 1'b0;
  logic         held_ovf  = 1'b0;

  serial_adder_controller #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .carryin  (carryin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryout (carryout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: unsigned sum with carry, and signed range test for overflow.
  task automatic ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         output logic [W-1:0] s, output logic co, output logic ov);
    int u;
    int sg;
    u  = int'(x) + int'(y) + int'(ci);
    sg = int'($signed(x)) + int'($signed(y)) + int'(ci);
    s  = u[W-1:0];
    co = (u >= 256);
    ov = (sg > 127) || (sg < -128);
  endtask

  // One complete add. With disturb set, operands change and start is
  // re-pulsed after E3 while RUN is in progress.
  task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input bit disturb, input string tag);
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    int           done_cnt;
    ref_add(x, y, ci, es, ec, eo);
    done_cnt = 0;
    @(negedge clk);
    a = x; b = y; carryin = ci; start = 1'b1;
    @(posedge clk); #1;                        // E0
    start = 1'b0;
    a = $urandom(); b = $urandom(); carryin = 1'($urandom());
    check({tag, " busy@E0"}, 32'(busy), 32'd1);
    check({tag, " done@E0"}, 32'(done), 32'd0);
    for (int k = 1; k <= W + 1; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
      if (disturb && k == 3) begin
        a = ~x; b = ~y; carryin = ~ci; start = 1'b1;
      end
      if (disturb && k == 4) start = 1'b0;
      if (k == W - 1) begin
        check({tag, " hold_sum"}, 32'(sum), 32'(held_sum));
        check({tag, " hold_cout"}, 32'(carryout), 32'(held_cout));
        check({tag, " early_done"}, 32'(done_cnt), 32'd0);
      end
      if (k == W) begin
        check({tag, " done@EW"}, 32'(done), 32'd1);
        check({tag, " busy@EW"}, 32'(busy), 32'd1);
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " carryout"}, 32'(carryout), 32'(ec));
        check({tag, " overflow"}, 32'(overflow), 32'(eo));
      end
      if (k == W + 1) begin
        check({tag, " done_drop"}, 32'(done), 32'd0);
        check({tag, " busy_drop"}, 32'(busy), 32'd0);
      end
    end
    check({tag, " done_count"}, 32'(done_cnt), 32'd1);
    held_sum = es; held_cout = ec; held_ovf = eo;
  endtask

  initial begin
    int saw;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; carryin = 1'b0;
    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst cout", 32'(carryout), 32'd0);
    check("rst ovf", 32'(overflow), 32'd0);
    @(negedge clk); reset = 1'b0;

    do_add(8'h0F, 8'h01, 1'b0, 1'b0, "0f+01");
    do_add(8'hFF, 8'h01, 1'b0, 1'b0, "ff+01");
    do_add(8'h7F, 8'h01, 1'b0, 1'b0, "7f+01");
    do_add(8'h80, 8'h80, 1'b0, 1'b0, "80+80");
    do_add(8'h00, 8'h00, 1'b1, 1'b0, "00+00+1");
    do_add(8'hFF, 8'hFF, 1'b1, 1'b0, "ff+ff+1");
    do_add(8'h5A, 8'h3C, 1'b0, 1'b1, "ignored_start");

    // Asynchronous reset mid-operation, a few ns after E3.
    @(negedge clk);
    a = 8'hC3; b = 8'h77; carryin = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst sum", 32'(sum), 32'd0);
    check("midrst cout", 32'(carryout), 32'd0);
    check("midrst ovf", 32'(overflow), 32'd0);
    @(negedge clk); @(negedge clk); reset = 1'b0;
    held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
    saw = 0;
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (done || busy) saw++;
    end
    check("post_rst idle", 32'(saw), 32'd0);
    do_add(8'h12, 8'h34, 1'b0, 1'b0, "12+34");

    // Continuous start: next accept lands at E(W+2).
    @(negedge clk);
    a = 8'h01; b = 8'h02; carryin = 1'b0; start = 1'b1;
    @(posedge clk); #1;                        // E0
    repeat (W + 1) @(posedge clk);
    #1;
    check("held_start idle@EW1", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("held_start accept@EW2", 32'(busy), 32'd1);
    start = 1'b0;
    saw = 0;
    for (int k = 1; k <= W + 2 && saw == 0; k++) begin
      @(posedge clk); #1;
      if (done) saw = k;
    end
    check("held_start done_latency", 32'(saw), 32'(W));
    check("held_start sum", 32'(sum), 32'h03);
    held_sum = 8'h03; held_cout = 1'b0; held_ovf = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      do_add(8'($urandom()), 8'($urandom()), 1'($urandom()), 1'($urandom_range(0, 3) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
